// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART core: parity modes,
// divisor calculation, parity helper and FSM state encodings.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Rounded clock divisor: one bit period in clk cycles.
    function automatic int unsigned uart_div(input longint unsigned clk_hz,
                                             input longint unsigned baud);
        return int'((clk_hz + baud / 2) / baud);
    endfunction

    // Parity bit to transmit (or expect) given the XOR of the payload bits.
    function automatic logic parity_bit(input int unsigned mode,
                                        input logic        ones_xor);
        return (mode == PAR_ODD) ? ~ones_xor : ones_xor;
    endfunction

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: runs 0..DIV-1, flags the last cycle of a period and
// the mid-point used to centre the receiver on the start bit.
module uart_bit_timer #(
    parameter int unsigned DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tick_full,
    output logic tick_half
);

    localparam int unsigned    CW   = $clog2(DIV);
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);
    localparam logic [CW-1:0]  HALF = CW'(DIV / 2 - 1);

    logic [CW-1:0] count;

    // Count through one bit period; load restarts the period at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick_full = (count == LAST);
    assign tick_half = (count == HALF);

endmodule

// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: ready/valid transmitter and a receiver
// with 2-FF synchroniser, start-bit glitch rejection and error flags.
module uart_core_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_done,
    output logic                 tx,
    input  logic                 rx,
    input  logic                 rx_en,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    localparam int unsigned DIV       = uart_div(CLK_HZ, BAUD);
    localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $fatal(1, "uart_core_param: DATA_BITS must be within 5..9");
    end
    if (PARITY > 2) begin : g_bad_parity
        $fatal(1, "uart_core_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $fatal(1, "uart_core_param: STOP_BITS must be 1 or 2");
    end
    if (DIV < 16) begin : g_bad_div
        $fatal(1, "uart_core_param: CLK_HZ/BAUD must be at least 16");
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t              tx_state, tx_state_next;
    logic [3:0]             tx_cnt, tx_cnt_next;
    logic [DATA_BITS-1:0]   tx_shift, tx_shift_next;
    logic                   tx_par, tx_par_next;
    logic                   tx_line_next;
    logic                   tx_load;
    logic                   tx_tick;
    logic                   tx_half_unused;

    uart_bit_timer #(.DIV(DIV)) u_tx_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (tx_load),
        .tick_full (tx_tick),
        .tick_half (tx_half_unused)
    );

    assign tx_ready = (tx_state == TX_IDLE);

    // TX next-state logic; tx is registered from the next state so the pin
    // is glitch-free and the start bit appears the cycle after handshake.
    always_comb begin
        tx_state_next = tx_state;
        tx_cnt_next   = tx_cnt;
        tx_shift_next = tx_shift;
        tx_par_next   = tx_par;
        tx_load       = 1'b0;
        tx_done       = 1'b0;
        unique case (tx_state)
            TX_IDLE: begin
                tx_load = 1'b1;
                if (tx_valid) begin
                    tx_state_next = TX_START;
                    tx_shift_next = tx_data;
                    tx_par_next   = parity_bit(PARITY, ^tx_data);
                    tx_cnt_next   = '0;
                end
            end
            TX_START: begin
                if (tx_tick) begin
                    tx_state_next = TX_DATA;
                    tx_cnt_next   = '0;
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    if (tx_cnt == LAST_DATA) begin
                        tx_cnt_next   = '0;
                        tx_state_next = (PARITY == PAR_NONE) ? TX_STOP : TX_PARITY;
                    end else begin
                        tx_cnt_next   = tx_cnt + 4'd1;
                        tx_shift_next = tx_shift >> 1;
                    end
                end
            end
            TX_PARITY: begin
                if (tx_tick) begin
                    tx_state_next = TX_STOP;
                    tx_cnt_next   = '0;
                end
            end
            TX_STOP: begin
                if (tx_tick) begin
                    if (tx_cnt == LAST_STOP) begin
                        tx_state_next = TX_IDLE;
                        tx_cnt_next   = '0;
                        tx_done       = 1'b1;
                    end else begin
                        tx_cnt_next = tx_cnt + 4'd1;
                    end
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase

        unique case (tx_state_next)
            TX_START:  tx_line_next = 1'b0;
            TX_DATA:   tx_line_next = tx_shift_next[0];
            TX_PARITY: tx_line_next = tx_par_next;
            default:   tx_line_next = 1'b1;
        endcase
    end

    // TX state and datapath registers; reset forces the line idle at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_next;
            tx_cnt   <= tx_cnt_next;
            tx_shift <= tx_shift_next;
            tx_par   <= tx_par_next;
            tx       <= tx_line_next;
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rx_state_t              rx_state, rx_state_next;
    logic [3:0]             rx_cnt, rx_cnt_next;
    logic [DATA_BITS-1:0]   rx_shift;
    logic                   rx_par_bit;
    logic                   rx_meta, rx_sync, rx_prev;
    logic                   rx_load, rx_full, rx_half;
    logic                   rx_shift_en, rx_par_en, rx_frame_done;
    logic                   rx_par_err_calc;

    uart_bit_timer #(.DIV(DIV)) u_rx_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (rx_load),
        .tick_full (rx_full),
        .tick_half (rx_half)
    );

    // Two-stage synchroniser plus one delayed copy for start-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // RX next-state logic. The timer is reloaded at the start-bit centre so
    // every later tick_full lands in the middle of a bit; it is also held at
    // zero whenever the FSM waits for a new start edge.
    always_comb begin
        rx_state_next = rx_state;
        rx_cnt_next   = rx_cnt;
        rx_load       = 1'b0;
        rx_shift_en   = 1'b0;
        rx_par_en     = 1'b0;
        rx_frame_done = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                rx_load = 1'b1;
                if (rx_en && rx_prev && !rx_sync) begin
                    rx_state_next = RX_START;
                    rx_cnt_next   = '0;
                end
            end
            RX_START: begin
                if (rx_half) begin
                    rx_load       = 1'b1;
                    rx_cnt_next   = '0;
                    rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_full) begin
                    rx_shift_en = 1'b1;
                    if (rx_cnt == LAST_DATA) begin
                        rx_cnt_next   = '0;
                        rx_state_next = (PARITY == PAR_NONE) ? RX_STOP : RX_PARITY;
                    end else begin
                        rx_cnt_next = rx_cnt + 4'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_full) begin
                    rx_par_en     = 1'b1;
                    rx_state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_full) begin
                    rx_frame_done = 1'b1;
                    rx_state_next = rx_sync ? RX_IDLE : RX_WAIT_IDLE;
                end
            end
            RX_WAIT_IDLE: begin
                rx_load = 1'b1;
                if (rx_sync) begin
                    rx_state_next = RX_IDLE;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    assign rx_par_err_calc = (PARITY != PAR_NONE) &&
                             (parity_bit(PARITY, ^rx_shift) != rx_par_bit);

    // RX state, shift register and frame outputs (data held until next frame).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state      <= RX_IDLE;
            rx_cnt        <= '0;
            rx_shift      <= '0;
            rx_par_bit    <= 1'b0;
            rx_valid      <= 1'b0;
            rx_data       <= '0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_state <= rx_state_next;
            rx_cnt   <= rx_cnt_next;
            rx_valid <= rx_frame_done;
            if (rx_shift_en) begin
                rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
            end
            if (rx_par_en) begin
                rx_par_bit <= rx_sync;
            end
            if (rx_frame_done) begin
                rx_data       <= rx_shift;
                rx_parity_err <= rx_par_err_calc;
                rx_frame_err  <= ~rx_sync;
            end
        end
    end

endmodule

// File: tb/tb_uart_core_param.sv
// Bench for uart_core_param: an 8N1 instance and a 7O2 instance, both at
// DIV = 100, checked against a bit-list frame model built in the bench.
module tb_uart_core_param;

    localparam int DIV = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       tx_valid_a, tx_ready_a, tx_done_a, tx_a, rx_a, rx_en_a;
    logic       rx_valid_a, rx_perr_a, rx_ferr_a;
    logic [7:0] tx_data_a, rx_data_a;

    logic       tx_valid_b, tx_ready_b, tx_done_b, tx_b, rx_b, rx_en_b;
    logic       rx_valid_b, rx_perr_b, rx_ferr_b;
    logic [6:0] tx_data_b, rx_data_b;

    int         sel;
    logic       tx_valid_drv;
    logic [8:0] tx_data_drv;
    logic       loop_a, loop_b, rx_drv_a, rx_drv_b;
    logic       cur_tx, cur_ready, cur_done;

    assign tx_valid_a = tx_valid_drv && (sel == 0);
    assign tx_valid_b = tx_valid_drv && (sel == 1);
    assign tx_data_a  = tx_data_drv[7:0];
    assign tx_data_b  = tx_data_drv[6:0];
    assign rx_a       = loop_a ? tx_a : rx_drv_a;
    assign rx_b       = loop_b ? tx_b : rx_drv_b;
    assign cur_tx     = (sel == 0) ? tx_a : tx_b;
    assign cur_ready  = (sel == 0) ? tx_ready_a : tx_ready_b;
    assign cur_done   = (sel == 0) ? tx_done_a : tx_done_b;

    uart_core_param #(
        .CLK_HZ(100_000_000), .BAUD(1_000_000),
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) dut_a (
        .clk(clk), .rst(rst),
        .tx_valid(tx_valid_a), .tx_data(tx_data_a), .tx_ready(tx_ready_a),
        .tx_done(tx_done_a), .tx(tx_a),
        .rx(rx_a), .rx_en(rx_en_a), .rx_valid(rx_valid_a), .rx_data(rx_data_a),
        .rx_parity_err(rx_perr_a), .rx_frame_err(rx_ferr_a)
    );

    uart_core_param #(
        .CLK_HZ(100_000_000), .BAUD(1_000_000),
        .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)
    ) dut_b (
        .clk(clk), .rst(rst),
        .tx_valid(tx_valid_b), .tx_data(tx_data_b), .tx_ready(tx_ready_b),
        .tx_done(tx_done_b), .tx(tx_b),
        .rx(rx_b), .rx_en(rx_en_b), .rx_valid(rx_valid_b), .rx_data(rx_data_b),
        .rx_parity_err(rx_perr_b), .rx_frame_err(rx_ferr_b)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every rx_valid cycle is recorded: {parity_err, frame_err, data[8:0]}.
    logic [10:0] qa[$];
    logic [10:0] qb[$];
    always @(negedge clk) begin
        if (rx_valid_a) qa.push_back({rx_perr_a, rx_ferr_a, 1'b0, rx_data_a});
        if (rx_valid_b) qb.push_back({rx_perr_b, rx_ferr_b, 2'b00, rx_data_b});
    end

    function automatic int cfg_bits(input int s);
        return (s == 0) ? 8 : 7;
    endfunction
    function automatic int cfg_par(input int s);
        return (s == 0) ? 0 : 1;
    endfunction
    function automatic int cfg_stop(input int s);
        return (s == 0) ? 1 : 2;
    endfunction

    // Reference frame as a list of line levels, one per bit period.
    logic frame_q[$];
    function automatic void build_frame(input int s, input logic [8:0] d,
                                        input bit inv_par, input logic stop_val);
        int ones = 0;
        logic p;
        frame_q.delete();
        frame_q.push_back(1'b0);
        for (int i = 0; i < cfg_bits(s); i++) begin
            frame_q.push_back(d[i]);
            if (d[i]) ones++;
        end
        if (cfg_par(s) != 0) begin
            if (cfg_par(s) == 1) p = (ones % 2 == 0);
            else                 p = (ones % 2 == 1);
            frame_q.push_back(inv_par ? ~p : p);
        end
        frame_q.push_back(stop_val);
        for (int i = 1; i < cfg_stop(s); i++) frame_q.push_back(1'b1);
    endfunction

    task automatic set_rx(input int s, input logic v);
        if (s == 0) rx_drv_a = v;
        else        rx_drv_b = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Send one frame and check the line at the first and last cycle of each
    // bit period, plus tx_done/tx_ready timing. Ends on the tx_ready cycle.
    task automatic run_tx(input int s, input logic [8:0] d, input bit keep, output int waited);
        int L, done_k, done_n, b, r;
        build_frame(s, d, 1'b0, 1'b1);
        L = frame_q.size();
        waited = 0;
        while (!cur_ready && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        check("tx_ready_wait", waited < 5000, 1);
        tx_data_drv  = d;
        tx_valid_drv = 1'b1;
        done_k = -1;
        done_n = 0;
        for (int k = 1; k <= L * DIV + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (!keep) tx_valid_drv = 1'b0;
                tx_data_drv = ~d;
                check("tx_ready_low", cur_ready, 0);
            end
            if (cur_done) begin
                done_n++;
                if (done_k < 0) done_k = k;
            end
            if (k <= L * DIV) begin
                b = (k - 1) / DIV;
                r = (k - 1) % DIV;
                if (r == 0 || r == DIV - 1)
                    check($sformatf("tx_s%0d_bit%0d_r%0d", s, b, r), cur_tx, frame_q[b]);
            end
        end
        check("tx_done_cycle", done_k, L * DIV);
        check("tx_done_width", done_n, 1);
        check("tx_ready_back", cur_ready, 1);
        check("tx_idle_high", cur_tx, 1);
    endtask

    task automatic drive_rx(input int s, input logic [8:0] d, input bit inv_par,
                            input logic stop_val, input int first, input int nbits);
        build_frame(s, d, inv_par, stop_val);
        for (int b = first; b < frame_q.size() && b < first + nbits; b++) begin
            set_rx(s, frame_q[b]);
            idle(DIV);
        end
    endtask

    task automatic expect_rx(input int s, input string tag, input logic [8:0] d,
                             input logic pe, input logic fe);
        logic [10:0] e;
        int n;
        n = (s == 0) ? qa.size() : qb.size();
        check({tag, "_count"}, n, 1);
        if (n > 0) begin
            if (s == 0) e = qa.pop_front();
            else        e = qb.pop_front();
            check({tag, "_data"}, e[8:0], d);
            check({tag, "_perr"}, e[10], pe);
            check({tag, "_ferr"}, e[9], fe);
        end
        qa.delete();
        qb.delete();
    endtask

    task automatic expect_none(input int s, input string tag);
        check(tag, (s == 0) ? qa.size() : qb.size(), 0);
        qa.delete();
        qb.delete();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [8:0] d, last_a;
        logic [10:0] e;

        rst = 1'b1; sel = 0; tx_valid_drv = 1'b0; tx_data_drv = '0;
        loop_a = 1'b1; loop_b = 1'b1; rx_drv_a = 1'b1; rx_drv_b = 1'b1;
        rx_en_a = 1'b1; rx_en_b = 1'b1;
        idle(3);
        check("rst_tx_a", tx_a, 1);
        check("rst_ready_a", tx_ready_a, 1);
        check("rst_done_a", tx_done_a, 0);
        check("rst_rxvalid_a", rx_valid_a, 0);
        check("rst_rxdata_a", rx_data_a, 0);
        check("rst_perr_a", rx_perr_a, 0);
        check("rst_ferr_a", rx_ferr_a, 0);
        check("rst_tx_b", tx_b, 1);
        check("rst_ready_b", tx_ready_b, 1);
        check("rst_rxdata_b", rx_data_b, 0);
        rst = 1'b0;
        idle(5);

        // 8N1 loopback: fixed pattern then random payloads
        sel = 0;
        run_tx(0, 9'h0A5, 1'b0, w);
        idle(20);
        expect_rx(0, "loop_a5", 9'h0A5, 1'b0, 1'b0);
        repeat (3) begin
            d = 9'($urandom_range(0, 255));
            run_tx(0, d, 1'b0, w);
            idle(20);
            expect_rx(0, "loop_rand_a", d, 1'b0, 1'b0);
        end

        // back-to-back with tx_valid held high throughout
        run_tx(0, 9'h001, 1'b1, w);
        run_tx(0, 9'h002, 1'b1, w);
        tx_valid_drv = 1'b0;
        check("b2b_gap", w, 0);
        idle(30);
        check("b2b_count", qa.size(), 2);
        if (qa.size() == 2) begin
            e = qa.pop_front();
            check("b2b_first", e[8:0], 9'h001);
            e = qa.pop_front();
            check("b2b_second", e[8:0], 9'h002);
        end
        qa.delete();
        last_a = 9'h002;

        // 7O2 loopback
        sel = 1;
        run_tx(1, 9'h035, 1'b0, w);
        idle(20);
        expect_rx(1, "loop_35", 9'h035, 1'b0, 1'b0);
        repeat (2) begin
            d = 9'($urandom_range(0, 127));
            run_tx(1, d, 1'b0, w);
            idle(20);
            expect_rx(1, "loop_rand_b", d, 1'b0, 1'b0);
        end

        // 7O2 driven frames: inverted then correct parity
        loop_b = 1'b0;
        d = 9'($urandom_range(0, 127));
        drive_rx(1, d, 1'b1, 1'b1, 0, 99);
        set_rx(1, 1'b1);
        idle(50);
        expect_rx(1, "par_inv", d, 1'b1, 1'b0);
        drive_rx(1, 9'h035, 1'b0, 1'b1, 0, 99);
        set_rx(1, 1'b1);
        idle(50);
        expect_rx(1, "par_ok", 9'h035, 1'b0, 1'b0);

        // 8N1 driven: stop bit 0, line held low afterwards
        sel = 0;
        loop_a = 1'b0;
        drive_rx(0, 9'h03C, 1'b0, 1'b0, 0, 99);
        idle(300);
        expect_rx(0, "frame_err", 9'h03C, 1'b0, 1'b1);
        set_rx(0, 1'b1);
        idle(200);
        expect_none(0, "after_frame_err");
        d = 9'($urandom_range(0, 255));
        drive_rx(0, d, 1'b0, 1'b1, 0, 99);
        set_rx(0, 1'b1);
        idle(50);
        expect_rx(0, "recover", d, 1'b0, 1'b0);
        last_a = d;

        // 30-cycle glitch is rejected, receiver still works afterwards
        set_rx(0, 1'b0);
        idle(30);
        set_rx(0, 1'b1);
        idle(1200);
        expect_none(0, "glitch");
        d = 9'($urandom_range(0, 255));
        drive_rx(0, d, 1'b0, 1'b1, 0, 99);
        set_rx(0, 1'b1);
        idle(50);
        expect_rx(0, "post_glitch", d, 1'b0, 1'b0);
        last_a = d;

        // rx_en low: no start detection, data held
        rx_en_a = 1'b0;
        drive_rx(0, ~last_a, 1'b0, 1'b1, 0, 99);
        set_rx(0, 1'b1);
        idle(200);
        expect_none(0, "rx_en_off");
        check("rx_data_hold", rx_data_a, last_a[7:0]);

        // rx_en dropped mid-frame: frame still completes
        rx_en_a = 1'b1;
        d = 9'($urandom_range(0, 255));
        drive_rx(0, d, 1'b0, 1'b1, 0, 3);
        rx_en_a = 1'b0;
        drive_rx(0, d, 1'b0, 1'b1, 3, 99);
        set_rx(0, 1'b1);
        idle(50);
        expect_rx(0, "en_mid_frame", d, 1'b0, 1'b0);
        rx_en_a = 1'b1;

        // reset in TX data bit 3 (loopback on)
        loop_a = 1'b1;
        tx_data_drv  = 9'h0F3;
        tx_valid_drv = 1'b1;
        @(negedge clk);
        tx_valid_drv = 1'b0;
        idle(4 * DIV + 49);
        check("pre_rst_tx_bit3", tx_a, 0);
        #2 rst = 1'b1;
        #1;
        check("rst_async_tx", tx_a, 1);
        check("rst_async_ready", tx_ready_a, 1);
        check("rst_async_done", tx_done_a, 0);
        idle(3);
        rst = 1'b0;
        idle(1500);
        expect_none(0, "rst_tx_no_rx");
        check("rst_clears_rxdata", rx_data_a, 0);
        d = 9'($urandom_range(0, 255));
        run_tx(0, d, 1'b0, w);
        idle(20);
        expect_rx(0, "after_rst", d, 1'b0, 1'b0);

        // reset mid RX frame
        loop_a = 1'b0;
        drive_rx(0, 9'h096, 1'b0, 1'b1, 0, 4);
        #2 rst = 1'b1;
        #1;
        check("rst_rx_valid", rx_valid_a, 0);
        set_rx(0, 1'b1);
        idle(3);
        rst = 1'b0;
        idle(1500);
        expect_none(0, "rst_rx_abort");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
Parametrised full-duplex UART core. It generalises the fixed 9600-8N1 TX/RX pair to a configurable baud rate, data width, parity mode and stop-bit count. It adds a TX ready/valid handshake, RX glitch rejection, and parity/framing error reporting. It sits between the board UART pins and the FIFO/packet logic, one instance per serial channel.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz
BAUD, 9600, line rate; DIV = round(CLK_HZ/BAUD), must be >= 16
DATA_BITS, 8, payload bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2; the receiver checks only the first stop bit

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
tx_valid  in  1  request to send tx_data
tx_data  in  DATA_BITS  frame payload, sampled on the handshake cycle
tx_ready  out  1  core can accept a new frame
tx_done  out  1  one-cycle pulse at the end of the last stop bit
tx  out  1  serial output, idle high
rx  in  1  serial input, asynchronous to clk
rx_en  in  1  receiver enable
rx_valid  out  1  one-cycle pulse when a frame completes
rx_data  out  DATA_BITS  received payload, held until the next rx_valid
rx_parity_err  out  1  qualified by rx_valid; always 0 when PARITY = 0
rx_frame_err  out  1  qualified by rx_valid; set when the sampled stop bit is 0

Behaviour:
- Reset values: tx = 1, tx_ready = 1, tx_done = 0, rx_valid = 0, rx_data = 0, both error flags = 0, both FSMs in IDLE, all counters = 0.
- Reset asserted mid-frame aborts the frame immediately. tx returns high asynchronously. No rx_valid is produced for the aborted frame.
- Elaboration checks: an illegal parameter value (DATA_BITS outside 5..9, PARITY > 2, STOP_BITS not 1 or 2, DIV < 16) is a fatal error.
- Bit timing: each side has its own counter, 0..DIV-1. A bit period is exactly DIV clk cycles.

TX FSM (states IDLE, START, DATA, PARITY, STOP):
- Handshake: tx_valid && tx_ready in cycle N latches tx_data. tx_ready goes low at N+1, and tx drives the start bit (0) from N+1.
- DATA: payload sent LSB first, DATA_BITS bit periods.
- PARITY: present only if PARITY != 0. Odd mode sends the bit that makes the total count of 1s odd; even mode makes it even.
- STOP: STOP_BITS x DIV cycles of 1.
- Completion: tx_done pulses in the final cycle of the last stop bit. tx_ready returns to 1 in the following cycle.
- Back-to-back: a frame accepted on the first tx_ready cycle gets no extra idle gap; its start bit follows immediately.
- tx_valid while tx_ready = 0 is ignored. No queuing.

RX FSM (states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE):
- Synchroniser: rx passes through a 2-FF synchroniser first. All timing references the synchronised signal.
- IDLE: a falling edge with rx_en = 1 enters START.
- START: at DIV/2 cycles the line is resampled. If it is high, the event is a glitch: return to IDLE with no output.
- DATA, PARITY, STOP: each sampled at the centre of its bit, DIV cycles apart.
- Frame output: at the stop-bit sample, rx_data, rx_parity_err and rx_frame_err update, and rx_valid pulses for exactly one cycle.
- Stop bit = 0: the FSM goes to WAIT_IDLE and holds there until the synchronised line is 1, then enters IDLE.
- Stop bit = 1: the FSM enters IDLE immediately. The next start edge may therefore occur in the remaining half stop bit.
- rx_en deasserted mid-frame: the frame completes normally. rx_en gates only new start detection.
- Independence: TX and RX operate fully in parallel. No shared state except the clock and reset.
- rx_data holds its value through rx_en = 0 and through idle periods. Only rst clears it.

Decomposition:
- Package uart_pkg: parity mode constants (PAR_NONE, PAR_ODD, PAR_EVEN), a compile-time DIV function, and the state encodings for both FSMs.
- Sub-module uart_bit_timer: a counter with load, tick at DIV-1 and tick at DIV/2. It is instantiated once in TX and once in RX.
- The TX and RX FSMs live in uart_core_param itself.

Test Plan:
All scenarios use CLK_HZ = 100e6, BAUD = 1e6 (DIV = 100) unless stated otherwise.
1. 8N1, send 0xA5 -> tx low for 100 cycles, then bits 1,0,1,0,0,1,0,1 at 100 cycles each, then high; tx_done at cycle 1000 after accept; loopback rx gives rx_data = 0xA5 with no errors.
2. DATA_BITS = 7, PARITY = 1 (odd), STOP_BITS = 2, send 0x35 -> 4 ones so parity bit = 1; frame lasts 11 bit periods (1100 cycles); RX reports rx_parity_err = 0. Drive an inverted parity bit -> rx_parity_err = 1.
3. Drive an RX frame 0x3C with the stop bit forced to 0 -> rx_valid with rx_frame_err = 1; no new frame is detected until rx is high again.
4. Pulse rx low for 30 cycles -> no rx_valid; the RX FSM is back in IDLE by cycle 52.
5. Assert tx_valid continuously with payloads 0x01 then 0x02 -> the second start bit begins exactly 1 cycle after tx_ready rises; no gap beyond the stop bit.
6. Assert rst mid-TX at data bit 3 -> tx = 1 and tx_ready = 1 immediately; the next frame transmits correctly. Assert rst mid-RX -> no rx_valid is produced.
